// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle control FSM (package mc_pkg).
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU,
    I_SUBU,
    I_JR,
    I_J,
    I_JAL,
    I_BEQ,
    I_ORI,
    I_LUI,
    I_LW,
    I_SW,
    I_ILL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_J    = 2'b10;
  localparam logic [1:0] NPC_JR   = 2'b11;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_RA   = 2'b10;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_IMM  = 2'b10;
  localparam logic [1:0] M2R_PC4  = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HIGH = 2'b10;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Unified instruction/data memory port with req/ack handshake.
interface mc_ctrl_fsm_if;
  logic mem_req;
  logic mem_wr;
  logic iord;
  logic mem_ack;

  modport master (output mem_req, output mem_wr, output iord, input mem_ack);
  modport slave  (input mem_req, input mem_wr, input iord, output mem_ack);
endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational op/funct classifier for the control FSM.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       illegal
);

  // Map op/funct onto an instruction class; anything unknown is illegal.
  always_comb begin
    iclass = I_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = I_ADDU;
          FN_SUBU: iclass = I_SUBU;
          FN_JR:   iclass = I_JR;
          default: iclass = I_ILL;
        endcase
      end
      OP_J:    iclass = I_J;
      OP_JAL:  iclass = I_JAL;
      OP_BEQ:  iclass = I_BEQ;
      OP_ORI:  iclass = I_ORI;
      OP_LUI:  iclass = I_LUI;
      OP_LW:   iclass = I_LW;
      OP_SW:   iclass = I_SW;
      default: iclass = I_ILL;
    endcase
    illegal = (iclass == I_ILL);
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: sequences fetch/decode/exec/mem/writeback over a
// shared memory port. Optional MC_CTRL_PERF_EN adds cycle/instruction counters.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TO_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero,
  mc_ctrl_fsm_if.master     bus,
  output logic              ir_wr,
  output logic              pc_wr,
  output logic [1:0]        npc_sel,
  output logic              reg_wr,
  output logic [1:0]        reg_dst,
  output logic [1:0]        mem_to_reg,
  output logic [1:0]        ext_op,
  output logic              alu_src_b,
  output logic [2:0]        alu_ctr,
  output logic              illegal_instr,
  output logic              mem_timeout
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       instr_cnt
`endif
);

  localparam int unsigned CW = (MEM_TO_CYC < 2) ? 1 : $clog2(MEM_TO_CYC + 1);

  state_t        state, state_nxt;
  iclass_t       iclass;
  logic          illegal;
  logic          req, wr, iord;
  logic [CW-1:0] wait_cnt, wait_nxt;

  mc_decode u_decode (
    .op      (op),
    .funct   (funct),
    .iclass  (iclass),
    .illegal (illegal)
  );

  assign bus.mem_req = req;
  assign bus.mem_wr  = wr;
  assign bus.iord    = iord;

  // State register, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (MEM_TO_CYC != 0 && wait_nxt == CW'(MEM_TO_CYC))
        mem_timeout <= 1'b1;
    end
  end

  // Only FETCH/MEM can hold their state, so "no state change" means "waiting for ack".
  always_comb begin
    wait_nxt = wait_cnt;
    if (state_nxt != state)
      wait_nxt = '0;
    else if (MEM_TO_CYC != 0 && wait_cnt != CW'(MEM_TO_CYC))
      wait_nxt = wait_cnt + 1'b1;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_nxt     = state;
    req           = 1'b0;
    wr            = 1'b0;
    iord          = 1'b0;
    ir_wr         = 1'b0;
    pc_wr         = 1'b0;
    npc_sel       = NPC_PC4;
    reg_wr        = 1'b0;
    reg_dst       = DST_RT;
    mem_to_reg    = M2R_ALU;
    ext_op        = EXT_ZERO;
    alu_src_b     = 1'b0;
    alu_ctr       = ALU_ADD;
    illegal_instr = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        req = 1'b1;
        if (bus.mem_ack) begin
          ir_wr     = 1'b1;
          pc_wr     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nxt = S_EXEC;
        case (iclass)
          I_J: begin
            pc_wr     = 1'b1;
            npc_sel   = NPC_J;
            state_nxt = S_FETCH;
          end
          I_JAL: begin
            pc_wr      = 1'b1;
            npc_sel    = NPC_J;
            reg_wr     = 1'b1;
            reg_dst    = DST_RA;
            mem_to_reg = M2R_PC4;
            state_nxt  = S_FETCH;
          end
          I_JR: begin
            pc_wr     = 1'b1;
            npc_sel   = NPC_JR;
            state_nxt = S_FETCH;
          end
          default: ;
        endcase
        if (illegal) begin
          illegal_instr = 1'b1;
          state_nxt     = S_FETCH;
        end
      end
      S_EXEC: begin
        state_nxt = S_WB;
        case (iclass)
          I_ADDU: alu_ctr = ALU_ADD;
          I_SUBU: alu_ctr = ALU_SUB;
          I_ORI: begin
            alu_ctr   = ALU_OR;
            ext_op    = EXT_ZERO;
            alu_src_b = 1'b1;
          end
          I_LUI: ext_op = EXT_HIGH;
          I_LW, I_SW: begin
            alu_ctr   = ALU_ADD;
            ext_op    = EXT_SIGN;
            alu_src_b = 1'b1;
            state_nxt = S_MEM;
          end
          I_BEQ: begin
            alu_ctr   = ALU_SUB;
            pc_wr     = zero;
            npc_sel   = NPC_BR;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        req  = 1'b1;
        iord = 1'b1;
        wr   = (iclass == I_SW);
        if (bus.mem_ack)
          state_nxt = (iclass == I_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_wr    = 1'b1;
        state_nxt = S_FETCH;
        case (iclass)
          I_ADDU, I_SUBU: reg_dst = DST_RD;
          I_LUI:          mem_to_reg = M2R_IMM;
          I_LW:           mem_to_reg = M2R_MEM;
          default: ;
        endcase
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef MC_CTRL_PERF_EN
  // Busy-cycle and retired-instruction counters, free-running with wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_IDLE)
        cyc_cnt <= cyc_cnt + 32'd1;
      if (state_nxt == S_FETCH && state inside {S_DECODE, S_EXEC, S_MEM, S_WB})
        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule
